slp_timer_ctrl: RTL and testbench
=================================

SLP_TIMER_CTRL -- requirements
Module: slp_timer_ctrl

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 50000000, the number of clk cycles between count ticks (legal values 2 to 2^26).
REQ-002 SHALL have port: clk  input  1  system clock, all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  start/resume button, synchronous level.
REQ-005 SHALL have port: pause  input  1  pause/resume button, synchronous level.
REQ-006 SHALL have port: cancel  input  1  abort button, synchronous level.
REQ-007 SHALL have port: en_machine  input  1  terminal flag from the 3-digit down counter, high while the count is 000.
REQ-008 SHALL have port: enable  output  1  count tick to the counter, one clk cycle wide.
REQ-009 SHALL have port: load  output  1  preset load strobe to the counter, one clk cycle wide.
REQ-010 SHALL have port: machine_on  output  1  high while the timed machine runs.
REQ-011 SHALL have port: done  output  1  high while a completed run is signalled.

Function
REQ-012 SHALL detect a rising edge on each of start, pause and cancel as (input high AND previous-cycle value low), using one history register per button.
REQ-013 SHALL implement the FSM states IDLE, LOAD, RUN, PAUSE and DONE, encoded freely.
REQ-014 IDLE SHALL hold all outputs low, and a start edge SHALL move the FSM to LOAD.
REQ-015 LOAD SHALL last exactly one cycle with load=1, clear the prescaler, then move to RUN.
REQ-016 RUN SHALL increment a 26-bit prescaler each cycle; at TICK_DIV-1 the prescaler SHALL wrap to 0 and drive enable=1 for that cycle only.
REQ-017 RUN SHALL drive machine_on=1.
REQ-018 RUN SHALL go to DONE in any cycle where en_machine=1, with enable forced low in that cycle; this applies from the first RUN cycle, so a 000 preset completes immediately.
REQ-019 A pause edge in RUN with en_machine=0 SHALL move the FSM to PAUSE.
REQ-020 PAUSE SHALL hold the prescaler value, drive enable=0 and machine_on=0, and a pause or start edge SHALL return the FSM to RUN with the prescaler continuing from its held value.
REQ-021 DONE SHALL drive done=1 and all other outputs low; a start edge SHALL move the FSM to LOAD (rerun).
REQ-022 A cancel edge SHALL move the FSM to IDLE from any state, clear the prescaler and not issue load.
REQ-023 Simultaneous events SHALL be prioritised: cancel > en_machine termination > pause > start.
REQ-024 SHALL keep enable and load mutually exclusive, so they are never high in the same cycle.
REQ-025 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from a button input to any output.

Reset
REQ-026 Reset SHALL asynchronously force IDLE, prescaler=0, enable=0, load=0, machine_on=0 and done=0.
REQ-027 Reset SHALL set the button history registers to 1, so a button held through reset release produces no edge.
REQ-028 Reset asserted mid-RUN or mid-PAUSE SHALL abandon the run, with no further enable or load pulses until a new start edge.

Verification (TICK_DIV=4)
REQ-029 The bench SHALL cover: reset, then a start edge at cycle 0 -> load=1 at cycle 1, RUN from cycle 2, enable pulses every 4th cycle, machine_on=1.
REQ-030 The bench SHALL cover: en_machine driven high in RUN on a prescaler=3 cycle -> no enable in that cycle, next cycle done=1, machine_on=0.
REQ-031 The bench SHALL cover: a pause edge at prescaler=2 -> no enable pulses while paused; after a start edge the next enable follows exactly 2 cycles later.
REQ-032 The bench SHALL cover: cancel, pause and en_machine all high in the same RUN cycle -> IDLE, done=0, no load.
REQ-033 The bench SHALL cover: start held high across reset release -> FSM stays IDLE; release then re-press -> LOAD.
REQ-034 The bench SHALL cover: a start edge in DONE -> exactly one load pulse, done drops, and the run restarts.

Source files
------------

// File: rtl/slp_timer_ctrl.sv
// Sleep-timer control FSM: edge-detected buttons drive load/run/pause/done
// sequencing and a prescaler that emits one-cycle count ticks.
module slp_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause,
  input  logic cancel,
  input  logic en_machine,
  output logic enable,
  output logic load,
  output logic machine_on,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [25:0] LAST = 26'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic        start_q, pause_q, cancel_q;
  logic        start_e, pause_e, cancel_e;

  assign start_e  = start  & ~start_q;
  assign pause_e  = pause  & ~pause_q;
  assign cancel_e = cancel & ~cancel_q;

  // History resets high so a button held through reset gives no edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      start_q  <= 1'b1;
      pause_q  <= 1'b1;
      cancel_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      start_q  <= start;
      pause_q  <= pause;
      cancel_q <= cancel;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (cancel_e) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_e) state_d = LOAD;
        end
        LOAD: begin
          presc_d = '0;
          state_d = RUN;
        end
        RUN: begin
          // Leaving RUN freezes the prescaler so a resume picks up exactly
          if (en_machine) begin
            state_d = DONE;
          end else if (pause_e) begin
            state_d = PAUSE;
          end else if (presc_q == LAST) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + 26'd1;
          end
        end
        PAUSE: begin
          if (pause_e || start_e) state_d = RUN;
        end
        DONE: begin
          if (start_e) state_d = LOAD;
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  assign load       = (state_q == LOAD);
  assign machine_on = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign enable     = (state_q == RUN) && (presc_q == LAST) && !en_machine;

endmodule

// File: tb/tb_slp_timer_ctrl.sv
// Directed bench for slp_timer_ctrl with TICK_DIV=4; per-cycle expected
// outputs {enable,load,machine_on,done} flow through a scoreboard queue.
module tb_slp_timer_ctrl;

  logic clk = 1'b0;
  logic reset, start, pause, cancel, en_machine;
  logic enable, load, machine_on, done;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  localparam logic [3:0] I = 4'b0000;
  localparam logic [3:0] L = 4'b0100;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] E = 4'b1010;
  localparam logic [3:0] D = 4'b0001;

  slp_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .cancel(cancel),
    .en_machine(en_machine),
    .enable(enable),
    .load(load),
    .machine_on(machine_on),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [3:0] obs;
      e = sb_q.pop_front();
      obs = {enable, load, machine_on, done};
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  end

  task automatic st(input logic r, input logic s, input logic p,
                    input logic c, input logic m,
                    input logic [3:0] exp, input string tag);
    sb_t e;
    @(posedge clk);
    #1;
    reset = r;
    start = s;
    pause = p;
    cancel = c;
    en_machine = m;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    cancel = 1'b0;
    en_machine = 1'b0;
    #2;
    n_vec++;
    assert ({enable, load, machine_on, done} === I) else begin
      n_err++;
      $error("FAIL reset_outs: observed %b expected %b",
             {enable, load, machine_on, done}, I);
    end
    st(1, 0, 0, 0, 0, I, "rst_hold");
    st(0, 0, 0, 0, 0, I, "rst_rel");
    st(0, 0, 0, 0, 0, I, "idle");

    st(0, 1, 0, 0, 0, I, "a_start");
    st(0, 0, 0, 0, 0, L, "a_load");
    st(0, 0, 0, 0, 0, R, "a_p0");
    st(0, 0, 0, 0, 0, R, "a_p1");
    st(0, 0, 0, 0, 0, R, "a_p2");
    st(0, 0, 0, 0, 0, E, "a_tick1");
    st(0, 0, 0, 0, 0, R, "a_p0b");
    st(0, 0, 0, 0, 0, R, "a_p1b");
    st(0, 0, 0, 0, 0, R, "a_p2b");
    st(0, 0, 0, 0, 0, E, "a_tick2");

    st(0, 0, 0, 0, 0, R, "b_p0");
    st(0, 0, 0, 0, 0, R, "b_p1");
    st(0, 0, 0, 0, 0, R, "b_p2");
    st(0, 0, 0, 0, 1, R, "b_term_noen");
    st(0, 0, 0, 0, 1, D, "b_done");
    st(0, 0, 0, 0, 1, D, "b_done_hold");

    st(0, 1, 0, 0, 1, D, "c_start_in_done");
    st(0, 0, 0, 0, 0, L, "c_reload");
    st(0, 0, 0, 0, 0, R, "c_p0");
    st(0, 0, 0, 0, 0, R, "c_p1");

    st(0, 0, 1, 0, 0, R, "d_pause_p2");
    st(0, 0, 0, 0, 0, I, "d_paused1");
    st(0, 0, 0, 0, 0, I, "d_paused2");
    st(0, 0, 0, 0, 0, I, "d_paused3");
    st(0, 1, 0, 0, 0, I, "d_resume");
    st(0, 0, 0, 0, 0, R, "d_p2");
    st(0, 0, 0, 0, 0, E, "d_tick");
    st(0, 0, 0, 0, 0, R, "d_p0");

    st(0, 0, 1, 1, 1, R, "e_all_p1");
    st(0, 0, 0, 0, 0, I, "e_idle");
    st(0, 0, 0, 0, 0, I, "e_noload1");
    st(0, 0, 0, 0, 0, I, "e_noload2");

    st(0, 1, 0, 0, 0, I, "f_start");
    st(0, 0, 0, 0, 0, L, "f_load");
    st(0, 0, 0, 0, 0, R, "f_p0");
    st(0, 0, 0, 0, 0, R, "f_p1");
    st(1, 1, 0, 0, 0, I, "f_rst_mid");
    st(1, 1, 0, 0, 0, I, "f_rst_hold");
    st(0, 1, 0, 0, 0, I, "g_rel_held");
    st(0, 1, 0, 0, 0, I, "g_held_idle");
    st(0, 1, 0, 0, 0, I, "g_held_idle2");
    st(0, 0, 0, 0, 0, I, "g_released");
    st(0, 1, 0, 0, 0, I, "g_repress");
    st(0, 0, 0, 0, 0, L, "g_load");
    st(0, 0, 0, 0, 0, R, "g_run");

    @(negedge clk);
    #1;
    n_vec++;
    assert (sb_q.size() === 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
